// File: rtl/aukv_pipe_ctrl.sv
// aukv_pipe_ctrl: RV32I hazard controller - EX/MEM scoreboard, forwarding selects, load-use/branch/dmem stalls.
// Forwarding is built only with AUKV_FWD_EN defined; otherwise every RAW hazard stalls.
module aukv_pipe_ctrl #(
    parameter int RF_AW = 5
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_id_valid,
    input  logic [RF_AW-1:0] i_id_rs1_addr,
    input  logic [RF_AW-1:0] i_id_rs2_addr,
    input  logic             i_id_rs1_used,
    input  logic             i_id_rs2_used,
    input  logic [RF_AW-1:0] i_id_rd_addr,
    input  logic             i_id_wb_we,
    input  logic             i_id_is_load,
    input  logic             i_br_taken,
    input  logic             i_dmem_busy,
    output logic [1:0]       o_rs1_fwsel,
    output logic [1:0]       o_rs2_fwsel,
    output logic             o_stall_if,
    output logic             o_stall_id,
    output logic             o_stall_ex,
    output logic             o_flush_id,
    output logic             o_flush_ex,
    output logic [1:0]       o_state
);
    typedef enum logic [1:0] {RUN = 2'd0, LDUSE = 2'd1, FLUSH = 2'd2, MEMWAIT = 2'd3} state_t;

    state_t           state, state_nxt;
    logic             ex_v, ex_we, ex_ld, mem_v, mem_we;
    logic [RF_AW-1:0] ex_rd, mem_rd;
    logic             use1, use2, ex_hit1, ex_hit2, mem_hit1, mem_hit2, ld_hit, hazard;

    assign use1     = i_id_valid && i_id_rs1_used && (i_id_rs1_addr != '0);
    assign use2     = i_id_valid && i_id_rs2_used && (i_id_rs2_addr != '0);
    assign ex_hit1  = use1 && ex_v && ex_we && (ex_rd == i_id_rs1_addr);
    assign ex_hit2  = use2 && ex_v && ex_we && (ex_rd == i_id_rs2_addr);
    assign mem_hit1 = use1 && mem_v && mem_we && (mem_rd == i_id_rs1_addr);
    assign mem_hit2 = use2 && mem_v && mem_we && (mem_rd == i_id_rs2_addr);
    assign ld_hit   = ex_ld && (ex_hit1 || ex_hit2);

`ifdef AUKV_FWD_EN
    logic [1:0] rs1_fw, rs2_fw;
    assign hazard = ld_hit;
    assign rs1_fw = ex_hit1 ? 2'd1 : mem_hit1 ? 2'd2 : 2'd0;
    assign rs2_fw = ex_hit2 ? 2'd1 : mem_hit2 ? 2'd2 : 2'd0;
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_rs1_fwsel <= 2'd0;
            o_rs2_fwsel <= 2'd0;
        end else if (!o_stall_ex) begin
            o_rs1_fwsel <= o_flush_ex ? 2'd0 : rs1_fw;
            o_rs2_fwsel <= o_flush_ex ? 2'd0 : rs2_fw;
        end
    end
`else
    assign hazard      = ld_hit || ex_hit1 || ex_hit2 || mem_hit1 || mem_hit2;
    assign o_rs1_fwsel = 2'd0;
    assign o_rs2_fwsel = 2'd0;
`endif

    // Outputs follow the state being entered so a hazard is acted on in the cycle it is seen.
    always_comb begin
        state_nxt  = RUN;
        o_stall_if = 1'b0;
        o_stall_id = 1'b0;
        o_stall_ex = 1'b0;
        o_flush_id = 1'b0;
        o_flush_ex = 1'b0;
        state_nxt  = i_dmem_busy ? MEMWAIT : i_br_taken ? FLUSH : hazard ? LDUSE : RUN;
        o_stall_if = i_rstn && (state_nxt == MEMWAIT || state_nxt == LDUSE);
        o_stall_id = i_rstn && (state_nxt == MEMWAIT || state_nxt == LDUSE);
        o_stall_ex = i_rstn && (state_nxt == MEMWAIT);
        o_flush_id = i_rstn && (state_nxt == FLUSH);
        o_flush_ex = i_rstn && (state_nxt == FLUSH || state_nxt == LDUSE);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state  <= RUN;
            ex_v   <= 1'b0;
            ex_we  <= 1'b0;
            ex_ld  <= 1'b0;
            ex_rd  <= '0;
            mem_v  <= 1'b0;
            mem_we <= 1'b0;
            mem_rd <= '0;
        end else begin
            state <= state_nxt;
            if (!o_stall_ex) begin
                ex_v   <= i_id_valid && !o_flush_ex;
                ex_we  <= i_id_wb_we;
                ex_ld  <= i_id_is_load;
                ex_rd  <= i_id_rd_addr;
                mem_v  <= ex_v;
                mem_we <= ex_we;
                mem_rd <= ex_rd;
            end
        end
    end

    assign o_state = state;
endmodule
